// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              done
);

    // state    | meaning
    // ---------+------------------------------------------------
    // S_IDLE   | line high, ready for a word
    // S_START  | start bit (low)
    // S_DATA   | data bits, shift_reg[0] on the line
    // S_PARITY | even parity of the captured word (optional)
    // S_STOP   | stop bit (high); done pulses on the next IDLE cycle

    localparam int                BIT_W     = $clog2(DATA_W + 1);
    localparam logic [7:0]        BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         baud_cnt, baud_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [DATA_W-1:0]  shift_reg, shift_nxt;
    logic               tx_nxt, in_ready_nxt, busy_nxt, done_nxt;
    logic               baud_last;
`ifdef SERIAL_TX_PARITY_EN
    logic [DATA_W-1:0]  data_word, data_word_nxt;
`endif

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef SERIAL_TX_PARITY_EN
            data_word <= '0;
`endif
            tx_line   <= 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
`ifdef SERIAL_TX_PARITY_EN
            data_word <= data_word_nxt;
`endif
            tx_line   <= tx_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
`ifdef SERIAL_TX_PARITY_EN
        data_word_nxt = data_word;
`endif
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt = S_START;
                    shift_nxt = in_data;
`ifdef SERIAL_TX_PARITY_EN
                    data_word_nxt = in_data;
`endif
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_nxt = S_DATA;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt  = baud_cnt + 8'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 8'd1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_nxt = S_STOP;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt  = baud_cnt + 8'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    state_nxt = S_IDLE;
                    baud_nxt  = '0;
                    done_nxt  = 1'b1;
                end else begin
                    baud_nxt  = baud_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                baud_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_nxt = ^data_word_nxt;
`endif
            default:  tx_nxt = 1'b1;
        endcase
        in_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt     = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: words queued on accept, decoded frames compared on completion.
// A second instance exercises CLKS_PER_BIT=1.
module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB  = DW + 3;
`else
    localparam int NB  = DW + 2;
`endif
    localparam int FRAME_LEN = NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_valid1;
    logic [DW-1:0] in_data, in_data1;
    logic          in_ready, tx_line, busy, done;
    logic          in_ready1, tx_line1, busy1, done1;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt    = 0;
    int frames_done = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_line(tx_line), .busy(busy), .done(done)
    );

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .tx_line(tx_line1), .busy(busy1), .done(done1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return w[idx-1];
`ifdef SERIAL_TX_PARITY_EN
        if (idx == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    // frame monitor: checks every line cycle against the popped expected word
    logic          in_frame = 1'b0;
    int            fc, err, idx;
    logic [DW-1:0] cur_exp, obs_w;
    logic          par_obs;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (in_frame && !busy) begin
                check_val("frame_len", fc, FRAME_LEN);
                check_val("done_at_end", done, 1'b1);
                check_val("line_errors", err, 0);
                check_val("word", obs_w, cur_exp);
`ifdef SERIAL_TX_PARITY_EN
                check_val("parity", par_obs, ^cur_exp);
`endif
                frames_done++;
                in_frame = 1'b0;
            end
            if (!in_frame && busy) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_frame", 1, 0);
                    cur_exp = '0;
                end else begin
                    cur_exp = exp_q.pop_front();
                end
                in_frame = 1'b1;
                fc = 0; err = 0; obs_w = '0; par_obs = 1'b0;
            end
            if (in_frame && busy) begin
                idx = fc / CPB;
                if (tx_line !== exp_bit(cur_exp, idx)) err++;
                if (fc % CPB == CPB / 2) begin
                    if (idx >= 1 && idx <= DW) obs_w[idx-1] = tx_line;
                    if (idx == DW + 1) par_obs = tx_line;
                end
                fc++;
            end
        end
    end

    task automatic send(input logic [DW-1:0] w);
        int t = 0;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (!in_ready) check_val("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        check_val("start_tx", tx_line, 1'b0);
        check_val("start_busy", busy, 1'b1);
        check_val("start_ready", in_ready, 1'b0);
    endtask

    task automatic wait_done(input int max);
        int t = 0;
        while (!done && t < max) begin @(posedge clk); #1; t++; end
        check_val("done_seen", done, 1'b1);
    endtask

    task automatic send1(input logic [DW-1:0] w);
        int t = 0;
        while (!in_ready1 && t < 50) begin @(posedge clk); #1; t++; end
        check_val("cpb1_ready", in_ready1, 1'b1);
        in_valid1 = 1'b1;
        in_data1  = w;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check_val("cpb1_bit", tx_line1, exp_bit(w, i));
            @(posedge clk); #1;
        end
        check_val("cpb1_done", done1, 1'b1);
        check_val("cpb1_busy_end", busy1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_tx", tx_line, 1'b1);
        check_val("rst_ready", in_ready, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("idle_tx", tx_line, 1'b1);
        check_val("idle_ready", in_ready, 1'b1);
        check_val("idle_busy", busy, 1'b0);
        check_val("idle_no_done", done_cnt, 0);

        send(8'hA5);
        wait_done(FRAME_LEN + 10);
        check_val("done_ready", in_ready, 1'b1);
        check_val("done_busy", busy, 1'b0);

        // back-to-back: second word offered on the done cycle
        send(8'h3C);
        wait_done(FRAME_LEN + 10);
        check_val("b2b_ready", in_ready, 1'b1);
        send(8'hC3);
        wait_done(FRAME_LEN + 10);

        // request while busy is ignored
        send(8'h00);
        repeat (15) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 8'hFF;
        check_val("ign_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        wait_done(FRAME_LEN + 10);

        // asynchronous reset during data bit 3
        send(8'h0F);
        repeat (17) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_tx", tx_line, 1'b1);
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_ready", in_ready, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h81);
        wait_done(FRAME_LEN + 10);

        send(8'h07);
        wait_done(FRAME_LEN + 10);
        send(8'h03);
        wait_done(FRAME_LEN + 10);
        for (int k = 0; k < 3; k++) begin
            send(DW'($urandom_range(0, 255)));
            wait_done(FRAME_LEN + 10);
        end

        send1(8'hA5);
        send1(8'h07);
        send1(8'h03);

        repeat (3) @(posedge clk);
        #1;
        check_val("queue_empty", exp_q.size(), 0);
        check_val("done_count", done_cnt, frames_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
